// File: rtl/disp_cmd_ctrl_if.sv
// FIFO-side and cell-RAM-side signals of the display command controller.
// master = the controller, slave = the FIFO/RAM environment driving it.
interface disp_cmd_ctrl_if #(
    parameter int ADDR_W = 12
);
    logic [7:0]        disp_cmd_in;
    logic              nef_in;
    logic              disp_cmd_rd;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_data;
    logic              bad_cmd;

    modport master (
        input  disp_cmd_in, nef_in,
        output disp_cmd_rd, ram_we, ram_addr, ram_data, bad_cmd
    );

    modport slave (
        output disp_cmd_in, nef_in,
        input  disp_cmd_rd, ram_we, ram_addr, ram_data, bad_cmd
    );
endinterface

// File: rtl/disp_cmd_ctrl.sv
// Reads command bytes from the display FIFO with a timed strobe, parses cursor
// and PUT commands, and writes {attr,char} words into the character-cell RAM.
module disp_cmd_ctrl #(
    parameter int COLS     = 80,
    parameter int ROWS     = 30,
    parameter int ADDR_W   = 12,
    parameter int RD_PULSE = 3,
    parameter int RD_GAP   = 2
) (
    input  logic           clk,
    input  logic           rst,
    disp_cmd_ctrl_if.master bus
);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_GAP} rd_state_e;
    typedef enum logic [2:0] {P_OPC, P_COL, P_ROW, P_CHR, P_ATR} parse_e;

    rd_state_e         rd_st, rd_nx;
    parse_e            ps, ps_nx;
    logic [7:0]        cnt, cnt_nx;
    logic              nef_m, nef_s;
    logic [7:0]        byte_q, char_q;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row, brow;
    logic [ADDR_W-1:0] row_base;
    logic              proc, walk_busy;
    logic              rd_q, we_q, bad_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       data_q;

    assign bus.disp_cmd_rd = rd_q;
    assign bus.ram_we      = we_q;
    assign bus.ram_addr    = addr_q;
    assign bus.ram_data    = data_q;
    assign bus.bad_cmd     = bad_q;

    // First GAP cycle is when the parser consumes the captured byte.
    assign proc = (rd_st == S_GAP) && (cnt == 8'd0);
    // row_base walks one row per cycle toward row; hold off reads until it arrives.
    assign walk_busy = (brow != row);

    always_comb begin
        rd_nx  = rd_st;
        cnt_nx = cnt + 8'd1;
        case (rd_st)
            S_IDLE: begin
                cnt_nx = 8'd0;
                if (nef_s && !walk_busy) rd_nx = S_LOW;
            end
            S_LOW: if (cnt == 8'(RD_PULSE - 1)) begin
                rd_nx  = S_GAP;
                cnt_nx = 8'd0;
            end
            S_GAP: if (cnt == 8'(RD_GAP - 1)) begin
                rd_nx  = S_IDLE;
                cnt_nx = 8'd0;
            end
            default: begin
                rd_nx  = S_IDLE;
                cnt_nx = 8'd0;
            end
        endcase
    end

    always_comb begin
        ps_nx = ps;
        if (proc) begin
            case (ps)
                P_OPC: case (byte_q)
                    8'h01:   ps_nx = P_COL;
                    8'h02:   ps_nx = P_ROW;
                    8'h03:   ps_nx = P_CHR;
                    default: ps_nx = P_OPC;
                endcase
                P_CHR:   ps_nx = P_ATR;
                default: ps_nx = P_OPC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_st    <= S_IDLE;
            ps       <= P_OPC;
            cnt      <= 8'd0;
            nef_m    <= 1'b0;
            nef_s    <= 1'b0;
            byte_q   <= 8'd0;
            char_q   <= 8'd0;
            col      <= '0;
            row      <= '0;
            brow     <= '0;
            row_base <= '0;
            rd_q     <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= 16'd0;
            bad_q    <= 1'b0;
        end else begin
            nef_m <= bus.nef_in;
            nef_s <= nef_m;
            rd_st <= rd_nx;
            cnt   <= cnt_nx;
            ps    <= ps_nx;
            rd_q  <= (rd_nx != S_LOW);
            we_q  <= 1'b0;
            if (rd_st == S_LOW && rd_nx == S_GAP) byte_q <= bus.disp_cmd_in;

            if (proc) begin
                case (ps)
                    P_OPC: case (byte_q)
                        8'h00, 8'h01, 8'h02, 8'h03: ;
                        8'h04: begin
                            col      <= '0;
                            row      <= '0;
                            brow     <= '0;
                            row_base <= '0;
                        end
                        default: bad_q <= 1'b1;
                    endcase
                    P_COL: col <= ({24'd0, byte_q} < 32'(COLS)) ? CW'(byte_q) : CW'(COLS - 1);
                    P_ROW: row <= ({24'd0, byte_q} < 32'(ROWS)) ? RW'(byte_q) : RW'(ROWS - 1);
                    P_CHR: char_q <= byte_q;
                    P_ATR: begin
                        we_q   <= 1'b1;
                        addr_q <= row_base + ADDR_W'(col);
                        data_q <= {byte_q, char_q};
                        if (col == CW'(COLS - 1)) begin
                            col <= '0;
                            if (row == RW'(ROWS - 1)) begin
                                row      <= '0;
                                brow     <= '0;
                                row_base <= '0;
                            end else begin
                                row      <= row + RW'(1);
                                brow     <= brow + RW'(1);
                                row_base <= row_base + ADDR_W'(COLS);
                            end
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                    default: ;
                endcase
            end else if (walk_busy) begin
                if (brow < row) begin
                    brow     <= brow + RW'(1);
                    row_base <= row_base + ADDR_W'(COLS);
                end else begin
                    brow     <= brow - RW'(1);
                    row_base <= row_base - ADDR_W'(COLS);
                end
            end
        end
    end
endmodule

// File: tb/tb_disp_cmd_ctrl.sv
// Directed bench: a FIFO model feeds byte vectors, a monitor logs RAM writes,
// and each vector's writes and bad_cmd are compared against hand-computed values.
module tb_disp_cmd_ctrl;
    localparam int COLS = 80, ROWS = 30, ADDR_W = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    disp_cmd_ctrl_if #(.ADDR_W(ADDR_W)) bus();

    disp_cmd_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .RD_PULSE(3), .RD_GAP(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [7:0]        fq[$];
    logic [ADDR_W-1:0] wa[$];
    logic [15:0]       wd[$];
    int checks = 0;
    int errors = 0;

    // FIFO model: presents the head byte while the strobe is low, pops on its rise.
    initial begin
        bus.disp_cmd_in = 8'h00;
        forever begin
            @(negedge bus.disp_cmd_rd);
            bus.disp_cmd_in = (fq.size() != 0) ? fq[0] : 8'h00;
            @(posedge bus.disp_cmd_rd);
            if (fq.size() != 0) void'(fq.pop_front());
        end
    end

    initial begin
        forever begin
            bus.nef_in = (fq.size() != 0);
            @(posedge clk);
            #1;
        end
    end

    always @(negedge clk) begin
        if (bus.ram_we === 1'b1) begin
            wa.push_back(bus.ram_addr);
            wd.push_back(bus.ram_data);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (fq.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " drain"}, fq.size(), 0);
        repeat (60) @(negedge clk);
    endtask

    task automatic wait_rd(input logic v, input string nm);
        int n = 0;
        while (bus.disp_cmd_rd !== v && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " strobe wait"}, bus.disp_cmd_rd, v);
    endtask

    typedef struct {
        string             nm;
        int                n;
        logic [95:0]       b;   // right-aligned, first byte most significant
        int                nwr;
        logic [ADDR_W-1:0] a0;
        logic [15:0]       d0;
        logic [ADDR_W-1:0] a1;
        logic [15:0]       d1;
        logic              bad;
    } vec_t;

    vec_t tv[10];

    initial begin
        int c, lo, hi, lows;

        tv[0] = '{"put245",  7,  96'h01_05_02_03_03_41_1F,             1, 245,  16'h1F41, 0,  16'h0,    1'b0};
        tv[1] = '{"put246",  3,  96'h03_42_07,                         1, 246,  16'h0742, 0,  16'h0,    1'b0};
        tv[2] = '{"eoswrap", 10, 96'h01_4F_02_1D_03_58_0F_03_59_0F,    2, 2399, 16'h0F58, 0,  16'h0F59, 1'b0};
        tv[3] = '{"clamp",   7,  96'h01_C8_02_FF_03_41_02,             1, 2399, 16'h0241, 0,  16'h0,    1'b0};
        tv[4] = '{"badop",   1,  96'h7E,                               0, 0,    16'h0,    0,  16'h0,    1'b1};
        tv[5] = '{"putbad",  3,  96'h03_43_05,                         1, 0,    16'h0543, 0,  16'h0,    1'b1};
        tv[6] = '{"home",    4,  96'h04_03_44_06,                      1, 0,    16'h0644, 0,  16'h0,    1'b1};
        tv[7] = '{"nopset",  8,  96'h00_01_0A_02_01_03_20_70,          1, 90,   16'h7020, 0,  16'h0,    1'b1};
        tv[8] = '{"rowwalk", 9,  96'h02_1D_02_02_01_04_03_21_01,       1, 164,  16'h0121, 0,  16'h0,    1'b1};
        tv[9] = '{"rowwrap", 10, 96'h01_4F_02_00_03_41_01_03_42_01,    2, 79,   16'h0141, 80, 16'h0142, 1'b1};

        // Reset with a non-empty FIFO: outputs stay at reset values.
        fq.push_back(8'h00);
        fq.push_back(8'h00);
        repeat (4) begin
            @(negedge clk);
            chk("rst rd", bus.disp_cmd_rd, 1'b1);
            chk("rst we", bus.ram_we, 1'b0);
        end
        chk("rst addr", bus.ram_addr, 0);
        chk("rst data", bus.ram_data, 0);
        chk("rst bad", bus.bad_cmd, 0);
        rst = 1'b0;

        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (bus.disp_cmd_rd !== 1'b0 && c < 20);
        chk("first strobe cycle", c, 3);
        lo = 1;
        while (lo < 20) begin
            @(negedge clk);
            if (bus.disp_cmd_rd !== 1'b0) break;
            lo++;
        end
        chk("strobe low len", lo, 3);
        hi = 1;
        while (hi < 20) begin
            @(negedge clk);
            if (bus.disp_cmd_rd === 1'b0) break;
            hi++;
        end
        chk("strobe gap >= 2", (hi >= 2 && hi < 20), 1'b1);
        wait_idle("nops");
        chk("nops no write", wa.size(), 0);

        for (int i = 0; i < 10; i++) begin
            wa.delete();
            wd.delete();
            for (int k = 0; k < tv[i].n; k++) fq.push_back(tv[i].b[8*(tv[i].n-1-k) +: 8]);
            wait_idle(tv[i].nm);
            chk({tv[i].nm, " writes"}, wa.size(), tv[i].nwr);
            if (tv[i].nwr >= 1 && wa.size() >= 1) begin
                chk({tv[i].nm, " addr0"}, wa[0], tv[i].a0);
                chk({tv[i].nm, " data0"}, wd[0], tv[i].d0);
                chk({tv[i].nm, " addr hold"}, bus.ram_addr, wa[wa.size()-1]);
            end
            if (tv[i].nwr >= 2 && wa.size() >= 2) begin
                chk({tv[i].nm, " addr1"}, wa[1], tv[i].a1);
                chk({tv[i].nm, " data1"}, wd[1], tv[i].d1);
            end
            chk({tv[i].nm, " bad"}, bus.bad_cmd, tv[i].bad);
        end

        // FIFO runs empty between the char opcode and its arguments.
        wa.delete();
        wd.delete();
        fq = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03};
        wait_idle("gap pre");
        lows = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.disp_cmd_rd !== 1'b1) lows++;
        end
        chk("gap no strobe", lows, 0);
        chk("gap no write", wa.size(), 0);
        fq.push_back(8'h41);
        fq.push_back(8'h1F);
        wait_idle("gap post");
        chk("gap writes", wa.size(), 1);
        if (wa.size() >= 1) begin
            chk("gap addr", wa[0], 0);
            chk("gap data", wd[0], 16'h1F41);
        end

        // Reset during the second low cycle of a read, parser mid-PUT.
        wa.delete();
        wd.delete();
        fq.push_back(8'h03);
        fq.push_back(8'h41);
        wait_rd(1'b0, "mid1");
        wait_rd(1'b1, "mid2");
        wait_rd(1'b0, "mid3");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst rd", bus.disp_cmd_rd, 1'b1);
        chk("midrst we", bus.ram_we, 1'b0);
        chk("midrst bad", bus.bad_cmd, 1'b0);
        rst = 1'b0;
        fq.push_back(8'h03);
        fq.push_back(8'h50);
        fq.push_back(8'h60);
        wait_idle("midrst");
        chk("midrst writes", wa.size(), 1);
        if (wa.size() >= 1) begin
            chk("midrst addr", wa[0], 0);
            chk("midrst data", wd[0], 16'h6050);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
